kij_loop_sequencer: RTL and testbench
=====================================

// Module: kij_loop_sequencer
// PURPOSE
//  Top-level scheduler for one full 3x3 convolution tile on the core controller.
//  Steps kij through 0..NUM_KIJ-1 and issues one core start per kij, waiting for core done each time.
//  Ping-pongs the psum bank select (rchip) between kij passes, then runs the final psum dump phase.
//  Sits between the testbench/host start and core_ctrl's kij, inst_tb and done signals.
// PARAMETERS
//  NUM_KIJ     9     kernel positions per tile (K*K); legal range 1..16
//  LEN_NIJ     16    output pixels per kij pass; also the dump length in cycles
//  KW          4     kij port width
//  TIMEOUT_CYC 1024  watchdog limit in cycles per kij pass (used only with the macro)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   begin a tile; sampled only in IDLE
//  abort       in   1   synchronous cancel; return to IDLE next cycle
//  core_done   in   1   one-cycle pulse from the core when a kij pass is finished
//  kij         out  KW  current kernel index sent to the core
//  start_kij   out  1   one-cycle pulse that launches a core pass
//  rchip       out  1   psum bank select (0: read mem1/write mem2; 1: the reverse)
//  acc_first   out  1   high during kij 0: core must not accumulate stale psums
//  final_read  out  1   psum dump strobe (inst_tb[3])
//  busy        out  1   high in every state except IDLE
//  done        out  1   one-cycle pulse when the tile is complete
//  err         out  1   sticky watchdog error; cleared by reset or by start
// BEHAVIOUR
//  Reset: state=IDLE. kij=0, rchip=0, all other outputs 0.
//  States: IDLE -> ISSUE -> WAIT -> (SWAP -> ISSUE)* -> DRAIN -> FIN -> IDLE.
//   IDLE : start=1 -> go to ISSUE; kij<=0, rchip<=0, err<=0.
//   ISSUE: start_kij=1 for exactly one cycle -> WAIT. acc_first=(kij==0).
//   WAIT : hold kij. On core_done: if kij==NUM_KIJ-1 -> DRAIN, else -> SWAP.
//   SWAP : one cycle; kij<=kij+1, rchip<=~rchip -> ISSUE.
//   DRAIN: final_read=1 for exactly LEN_NIJ cycles (counter 0..LEN_NIJ-1) -> FIN.
//   FIN  : done=1 for one cycle -> IDLE. kij and rchip hold their last values until the next start.
//  Latency: start -> first start_kij = 1 cycle.
//  Latency: core_done -> next start_kij = 2 cycles (SWAP, ISSUE).
//  Latency: last core_done -> done = LEN_NIJ+1 cycles.
//  start while busy: ignored.
//  core_done outside WAIT (including in the same cycle as start_kij): ignored.
//  abort (any state, priority over every other input): next state IDLE, outputs as reset, err held.
//  NUM_KIJ=1: no SWAP ever occurs; rchip stays 0.
//  In general, final rchip = (NUM_KIJ-1) mod 2.
//  kij never exceeds NUM_KIJ-1; the kij counter has no wrap.
//  reset mid-tile: same result as abort, and err is also cleared.
// CONFIGURATION
//  KIJ_SEQ_WATCHDOG_EN defined:
//   - A cycle counter clears on entry to WAIT.
//   - If it reaches TIMEOUT_CYC before core_done: err<=1, state -> IDLE, no done pulse.
//  KIJ_SEQ_WATCHDOG_EN undefined:
//   - WAIT waits indefinitely; err is tied to 0.
//   - TIMEOUT_CYC is unused.
// STRUCTURE
//  Package kij_seq_pkg holds:
//   - state localparams (IDLE=0, ISSUE, WAIT, SWAP, DRAIN, FIN)
//   - the clog2 helper used to size the DRAIN and watchdog counters
//  One sub-module, kij_seq_watchdog:
//   - counter plus compare, with clr/en/expired ports
//   - instantiated only under the macro
// TESTING
//  1. reset, start pulse, core_done 20 cycles after each start_kij
//     -> kij steps 0..8; rchip sequence 0,1,0,...,0
//     -> 9 start_kij pulses; final_read high 16 cycles; one done pulse.
//  2. start asserted again mid-tile, and core_done injected in ISSUE
//     -> both ignored; pulse count stays 9.
//  3. abort at kij=4 during WAIT -> IDLE next cycle; kij=0, busy=0, no done.
//     Then a fresh start completes normally.
//  4. NUM_KIJ=1 -> one start_kij, rchip stays 0, acc_first=1, 16 dump cycles, done.
//  5. Macro on, TIMEOUT_CYC=32, core_done withheld
//     -> err=1 at WAIT entry+32 cycles; IDLE; no done. Next start clears err.
//  6. reset asserted during DRAIN -> all outputs 0 the next cycle; final_read drops immediately.

Source files
------------

// File: rtl/kij_seq_pkg.sv
// Shared types and helpers for the kij loop sequencer: FSM state encoding and
// the ceiling-log2 used to size its counters.
package kij_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        SWAP  = 3'd3,
        DRAIN = 3'd4,
        FIN   = 3'd5
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

endpackage

// File: rtl/kij_seq_watchdog.sv
// Per-pass watchdog for the kij sequencer (only built with KIJ_SEQ_WATCHDOG_EN):
// counts enabled cycles since the last clr and flags when LIMIT cycles have elapsed.
module kij_seq_watchdog
    import kij_seq_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (clog2(LIMIT + 1) < 1) ? 1 : clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    // Fires during the LIMIT-th enabled cycle so the owner leaves on that edge.
    assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/kij_loop_sequencer.sv
// Steps kij through one 3x3 conv tile, launching one core pass per kij, then
// runs the psum dump. Optional watchdog: define KIJ_SEQ_WATCHDOG_EN.
module kij_loop_sequencer
    import kij_seq_pkg::*;
#(
    parameter int NUM_KIJ = 9,
    parameter int LEN_NIJ = 16,
    parameter int KW      = 4
`ifdef KIJ_SEQ_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          core_done,
    output logic [KW-1:0] kij,
    output logic          start_kij,
    output logic          rchip,
    output logic          acc_first,
    output logic          final_read,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int            DW         = (clog2(LEN_NIJ) < 1) ? 1 : clog2(LEN_NIJ);
    localparam logic [KW-1:0] LAST_KIJ   = KW'(NUM_KIJ - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(LEN_NIJ - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt;
    logic          timeout;

    // Core handshake: start_kij is a single-cycle request issued from ISSUE; the
    // core answers with a single-cycle core_done, honoured only while in WAIT.
`ifdef KIJ_SEQ_WATCHDOG_EN
    kij_seq_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == ISSUE),
        .en      (state == WAIT),
        .expired (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (!abort) begin
            if (state == IDLE && start) begin
                err <= 1'b0;
            end else if (state == WAIT && !core_done && timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = ISSUE;
                ISSUE:   state_nxt = WAIT;
                WAIT: begin
                    if (core_done) begin
                        state_nxt = (kij == LAST_KIJ) ? DRAIN : SWAP;
                    end else if (timeout) begin
                        state_nxt = IDLE;
                    end
                end
                SWAP:    state_nxt = ISSUE;
                DRAIN:   if (drain_cnt == LAST_DRAIN) state_nxt = FIN;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            kij       <= '0;
            rchip     <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (abort) begin
                kij       <= '0;
                rchip     <= 1'b0;
                drain_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            kij   <= '0;
                            rchip <= 1'b0;
                        end
                    end
                    SWAP: begin
                        kij   <= kij + KW'(1);
                        rchip <= ~rchip;
                    end
                    DRAIN: begin
                        drain_cnt <= (drain_cnt == LAST_DRAIN) ? '0 : drain_cnt + DW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign start_kij  = (state == ISSUE);
    // Covers the whole first pass so the core never accumulates a stale bank.
    assign acc_first  = (state == ISSUE || state == WAIT) && (kij == '0);
    assign final_read = (state == DRAIN);
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

endmodule

// File: tb/tb_kij_loop_sequencer.sv
// Directed bench for kij_loop_sequencer: a 9-kij instance (tile, ignored
// inputs, abort, watchdog, reset in DRAIN) and a 1-kij instance.
module tb_kij_loop_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       a_start = 0, a_abort = 0, a_core_done = 0;
    logic [3:0] a_kij;
    logic       a_start_kij, a_rchip, a_acc_first, a_final_read, a_busy, a_done, a_err;

    logic       b_start = 0, b_abort = 0, b_core_done = 0;
    logic [3:0] b_kij;
    logic       b_start_kij, b_rchip, b_acc_first, b_final_read, b_busy, b_done, b_err;

    int checks = 0;
    int errors = 0;

    int a_sk_cnt = 0, a_fr_cnt = 0, a_done_cnt = 0;
    int b_sk_cnt = 0, b_fr_cnt = 0, b_done_cnt = 0;

    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    kij_loop_sequencer #(
        .NUM_KIJ(9), .LEN_NIJ(16), .KW(4)
`ifdef KIJ_SEQ_WATCHDOG_EN
        , .TIMEOUT_CYC(32)
`endif
    ) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .core_done(a_core_done), .kij(a_kij), .start_kij(a_start_kij),
        .rchip(a_rchip), .acc_first(a_acc_first), .final_read(a_final_read),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    kij_loop_sequencer #(
        .NUM_KIJ(1), .LEN_NIJ(16), .KW(4)
`ifdef KIJ_SEQ_WATCHDOG_EN
        , .TIMEOUT_CYC(32)
`endif
    ) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .core_done(b_core_done), .kij(b_kij), .start_kij(b_start_kij),
        .rchip(b_rchip), .acc_first(b_acc_first), .final_read(b_final_read),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every launch on dut_a must match the next expected {rchip,kij}.
    always @(posedge clk) begin
        #1;
        if (a_start_kij) begin
            a_sk_cnt++;
            if (exp_q.size() == 0) check("sk_unexpected", 1, 0);
            else check("kij_seq", {27'd0, a_rchip, a_kij}, {27'd0, exp_q.pop_front()});
        end
        if (a_final_read) a_fr_cnt++;
        if (a_done)       a_done_cnt++;
        if (b_start_kij)  b_sk_cnt++;
        if (b_final_read) b_fr_cnt++;
        if (b_done)       b_done_cnt++;
    end

    task automatic expect_passes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({i[0], i[3:0]});
    endtask

    task automatic clear_counts();
        a_sk_cnt = 0; a_fr_cnt = 0; a_done_cnt = 0;
    endtask

    // Called at a negedge; leaves dut_a in ISSUE at the returning negedge.
    task automatic start_tile();
        a_start = 1;
        @(negedge clk);
        a_start = 0;
        check("start_lat", a_start_kij, 1);
    endtask

    // Plays the core for n passes; optional ignored-input injection, abort, reset in DRAIN.
    task automatic serve(input int n, input int gap, input bit inject, input int abort_at,
                         input bit rst_in_drain);
        for (int p = 0; p < n; p++) begin
            check("acc_first", a_acc_first, (p == 0) ? 1 : 0);
            if (inject) begin
                a_core_done = 1;
                a_start = 1;
            end
            @(negedge clk);
            a_core_done = 0;
            a_start = 0;
            check("sk_one_cycle", a_start_kij, 0);
            if (p == abort_at) begin
                repeat (3) @(negedge clk);
                a_abort = 1;
                @(negedge clk);
                a_abort = 0;
                check("abort_busy", a_busy, 0);
                check("abort_kij", a_kij, 0);
                check("abort_rchip", a_rchip, 0);
                check("abort_fr", a_final_read, 0);
                return;
            end
            repeat (gap) @(negedge clk);
            a_core_done = 1;
            @(negedge clk);
            a_core_done = 0;
            if (p < n - 1) begin
                check("swap_no_sk", a_start_kij, 0);
                @(negedge clk);
                check("swap_lat", a_start_kij, 1);
            end
        end
        check("drain_fr_first", a_final_read, 1);
        if (rst_in_drain) begin
            @(negedge clk);
            reset = 1;
            @(negedge clk);
            reset = 0;
            check("rst_fr", a_final_read, 0);
            check("rst_busy", a_busy, 0);
            check("rst_kij", a_kij, 0);
            check("rst_rchip", a_rchip, 0);
            check("rst_done", a_done, 0);
            check("rst_err", a_err, 0);
            return;
        end
        repeat (15) @(negedge clk);
        check("drain_fr_last", a_final_read, 1);
        check("done_early", a_done, 0);
        @(negedge clk);
        check("done_lat", a_done, 1);
        check("fin_fr", a_final_read, 0);
        @(negedge clk);
        check("done_pulse", a_done, 0);
        check("idle_busy", a_busy, 0);
        check("final_kij", a_kij, n - 1);
        check("final_rchip", a_rchip, (n - 1) % 2);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_kij0", a_kij, 0);
        check("rst_rchip0", a_rchip, 0);
        check("rst_busy0", a_busy, 0);
        check("rst_sk0", a_start_kij, 0);
        check("rst_done0", a_done, 0);
        check("rst_err0", a_err, 0);
        check("rst_acc0", a_acc_first, 0);
        reset = 0;
        @(negedge clk);

        // Test 1: full tile, core_done 20 cycles after each launch
        clear_counts();
        expect_passes(9);
        start_tile();
        serve(9, 20, 0, -1, 0);
        check("t1_sk_cnt", a_sk_cnt, 9);
        check("t1_fr_cnt", a_fr_cnt, 16);
        check("t1_done_cnt", a_done_cnt, 1);

        // Test 2: start and core_done injected during every ISSUE
        repeat (2) @(negedge clk);
        clear_counts();
        expect_passes(9);
        start_tile();
        serve(9, 5, 1, -1, 0);
        check("t2_sk_cnt", a_sk_cnt, 9);
        check("t2_done_cnt", a_done_cnt, 1);

        // Test 3: abort in WAIT at kij=4, then a fresh tile
        repeat (2) @(negedge clk);
        clear_counts();
        expect_passes(5);
        start_tile();
        serve(9, 6, 0, 4, 0);
        repeat (4) @(negedge clk);
        check("t3_idle", a_busy, 0);
        check("t3_done_cnt", a_done_cnt, 0);
        check("t3_sk_cnt", a_sk_cnt, 5);
        clear_counts();
        expect_passes(9);
        start_tile();
        serve(9, 3, 0, -1, 0);
        check("t3b_done_cnt", a_done_cnt, 1);

        // Test 4: single-kij instance
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        check("b_sk", b_start_kij, 1);
        check("b_acc_first", b_acc_first, 1);
        check("b_kij", b_kij, 0);
        repeat (4) @(negedge clk);
        b_core_done = 1;
        @(negedge clk);
        b_core_done = 0;
        check("b_fr", b_final_read, 1);
        for (int i = 0; i < 40; i++) begin
            if (b_done) break;
            @(negedge clk);
        end
        check("b_done_seen", b_done, 1);
        @(negedge clk);
        check("b_sk_cnt", b_sk_cnt, 1);
        check("b_fr_cnt", b_fr_cnt, 16);
        check("b_done_cnt", b_done_cnt, 1);
        check("b_rchip", b_rchip, 0);
        check("b_busy", b_busy, 0);

        // Test 5: core_done withheld
        clear_counts();
        expect_passes(1);
        start_tile();
`ifdef KIJ_SEQ_WATCHDOG_EN
        repeat (32) @(negedge clk);
        check("wd_err_before", a_err, 0);
        check("wd_busy_before", a_busy, 1);
        @(negedge clk);
        check("wd_err", a_err, 1);
        check("wd_idle", a_busy, 0);
        repeat (3) @(negedge clk);
        check("wd_err_sticky", a_err, 1);
        check("wd_no_done", a_done_cnt, 0);
        expect_passes(1);
        start_tile();
        check("wd_err_cleared", a_err, 0);
        a_abort = 1;
        @(negedge clk);
        a_abort = 0;
        check("wd_abort_idle", a_busy, 0);
`else
        repeat (40) @(negedge clk);
        check("nowd_err", a_err, 0);
        check("nowd_busy", a_busy, 1);
        a_abort = 1;
        @(negedge clk);
        a_abort = 0;
        check("nowd_abort_idle", a_busy, 0);
        check("nowd_no_done", a_done_cnt, 0);
`endif

        // Test 6: reset during DRAIN
        repeat (2) @(negedge clk);
        clear_counts();
        expect_passes(9);
        start_tile();
        serve(9, 2, 0, -1, 1);
        repeat (3) @(negedge clk);
        check("t6_no_done", a_done_cnt, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
